// File: rtl/framer_pkg.sv
// Shared framing definitions: FSM state encoding, pass_out sideband bit map and default line width.
// The filter chain's pass decoders import this package too.
package framer_pkg;

    typedef enum logic [1:0] {
        SYNC        = 2'd0,
        VBLANK_WAIT = 2'd1,
        LINE        = 2'd2,
        FRAME_GAP   = 2'd3
    } framer_state_e;

    localparam int PASS_W     = 24;
    localparam int PASS_DE    = 0;
    localparam int PASS_SOL   = 1;
    localparam int PASS_EOL   = 2;
    localparam int PASS_SOF   = 3;
    localparam int PASS_EOF   = 4;
    localparam int PASS_TRUNC = 5;

    localparam int DEF_COL = 640;

endpackage

// File: rtl/raster_framer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with increment loads 1.
module sat_counter #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && count != '1) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/raster_framer.sv
// Camera stream framer: turns fval/lval/dval + pixel into registered pixel, x/y coordinates,
// measured line width and the pass_out sideband word, all with one cycle of latency.
module raster_framer #(
    parameter int CW      = 13,
    parameter int DEF_COL = framer_pkg::DEF_COL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_fval,
    input  logic          in_lval,
    input  logic          in_dval,
    input  logic [23:0]   in_pixel,
    output logic [23:0]   pixel_out,
    output logic [CW-1:0] x_count,
    output logic [CW-1:0] y_count,
    output logic [CW-1:0] col,
    output logic [23:0]   pass_out
);
    import framer_pkg::*;

    framer_state_e state, nxt_state;
    logic          fval_q, lval_q, trunc_q;
    logic          lv, fval_rise, lval_rise;
    logic          sof_n, eol_n, eof_n, trunc_n;
    logic          line_start, line_end, in_line, accept, sol_n;
    logic [CW-1:0] x_cnt, y_cnt, x_idx;
    logic [PASS_W-1:0] pass_n;

    assign lv        = in_fval & in_lval;
    assign fval_rise = in_fval & ~fval_q;
    assign lval_rise = lv & ~lval_q;

    always_comb begin
        nxt_state  = state;
        sof_n      = 1'b0;
        eol_n      = 1'b0;
        eof_n      = 1'b0;
        trunc_n    = trunc_q;
        line_start = 1'b0;
        line_end   = 1'b0;
        in_line    = 1'b0;
        case (state)
            SYNC, FRAME_GAP: begin
                if (fval_rise) begin
                    nxt_state = VBLANK_WAIT;
                    sof_n     = 1'b1;
                    trunc_n   = 1'b0;
                end
            end
            VBLANK_WAIT: begin
                if (!in_fval) begin
                    nxt_state = FRAME_GAP;
                    eof_n     = 1'b1;
                end else if (lval_rise) begin
                    nxt_state  = LINE;
                    line_start = 1'b1;
                    in_line    = 1'b1;
                end
            end
            LINE: begin
                // fval dropping mid-line truncates it: col keeps the last good width
                if (!in_fval) begin
                    nxt_state = FRAME_GAP;
                    eol_n     = 1'b1;
                    eof_n     = 1'b1;
                    trunc_n   = 1'b1;
                end else if (!lv) begin
                    nxt_state = VBLANK_WAIT;
                    eol_n     = 1'b1;
                    line_end  = 1'b1;
                end else begin
                    in_line = 1'b1;
                end
            end
            default: nxt_state = SYNC;
        endcase
    end

    // The first pixel may arrive on the lval rising cycle, before x_cnt has been cleared.
    assign accept = in_line & in_dval;
    assign x_idx  = line_start ? '0 : x_cnt;
    assign sol_n  = accept & (line_start | (x_cnt == '0));

    always_comb begin
        pass_n             = '0;
        pass_n[PASS_DE]    = accept;
        pass_n[PASS_SOL]   = sol_n;
        pass_n[PASS_EOL]   = eol_n;
        pass_n[PASS_SOF]   = sof_n;
        pass_n[PASS_EOF]   = eof_n;
        pass_n[PASS_TRUNC] = trunc_n;
    end

    sat_counter #(.W(CW)) u_x_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (line_start),
        .inc   (accept),
        .count (x_cnt)
    );

    sat_counter #(.W(CW)) u_y_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (sof_n),
        .inc   (line_end),
        .count (y_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            fval_q    <= 1'b1;  // a frame already running at reset must not look like a rise
            lval_q    <= 1'b1;
            trunc_q   <= 1'b0;
            pixel_out <= '0;
            x_count   <= '0;
            y_count   <= '0;
            col       <= CW'(DEF_COL);
            pass_out  <= '0;
        end else begin
            state    <= nxt_state;
            fval_q   <= in_fval;
            lval_q   <= lv;
            trunc_q  <= trunc_n;
            pass_out <= pass_n;
            if (accept) begin
                pixel_out <= in_pixel;
                x_count   <= x_idx;
                y_count   <= y_cnt;
            end
            if (line_end && x_cnt != '0) begin
                col <= x_cnt;
            end
        end
    end

endmodule

// File: tb/tb_raster_framer.sv
// Bench for raster_framer: two instances (CW=13 and CW=4) share directed + random stimulus and are
// checked every cycle against a line/frame-level reference model.
module tb_raster_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_fval = 1'b0, in_lval = 1'b0, in_dval = 1'b0;
    logic [23:0] in_pixel = '0;

    logic [23:0] pix_a, pass_a, pix_b, pass_b;
    logic [12:0] x_a, y_a, col_a;
    logic [3:0]  x_b, y_b, col_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    raster_framer #(.CW(13), .DEF_COL(640)) dut_a (
        .clk(clk), .rst(rst), .in_fval(in_fval), .in_lval(in_lval), .in_dval(in_dval),
        .in_pixel(in_pixel), .pixel_out(pix_a), .x_count(x_a), .y_count(y_a), .col(col_a),
        .pass_out(pass_a)
    );

    raster_framer #(.CW(4), .DEF_COL(10)) dut_b (
        .clk(clk), .rst(rst), .in_fval(in_fval), .in_lval(in_lval), .in_dval(in_dval),
        .in_pixel(in_pixel), .pixel_out(pix_b), .x_count(x_b), .y_count(y_b), .col(col_b),
        .pass_out(pass_b)
    );

    typedef struct {
        bit          in_frame, in_line, prev_f, prev_l, trunc;
        int          cnt, row, col, x, y;
        logic [23:0] pix, pass;
    } mdl_t;

    mdl_t ma, mb;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock of the stream, described in terms of frames, lines and accepted pixels.
    function automatic void mstep(inout mdl_t m, input bit r, input bit f, input bit l, input bit d,
                                  input logic [23:0] p, input int maxv, input int defcol);
        bit le, de, sol, eol, sof, eof;
        le = f & l; de = 0; sol = 0; eol = 0; sof = 0; eof = 0;
        if (r) begin
            m.in_frame = 0; m.in_line = 0; m.prev_f = 1; m.prev_l = 1; m.trunc = 0;
            m.cnt = 0; m.row = 0; m.col = defcol; m.pix = '0; m.x = 0; m.y = 0; m.pass = '0;
            return;
        end
        if (!m.in_frame) begin
            if (f && !m.prev_f) begin
                sof = 1; m.in_frame = 1; m.row = 0; m.trunc = 0;
            end
        end else if (!f) begin
            eof = 1;
            if (m.in_line) begin eol = 1; m.trunc = 1; end
            m.in_frame = 0; m.in_line = 0;
        end else if (m.in_line && !le) begin
            eol = 1;
            if (m.cnt > 0) m.col = imin(m.cnt, maxv);
            m.row = imin(m.row + 1, maxv);
            m.in_line = 0;
        end else begin
            if (!m.in_line && le && !m.prev_l) begin m.in_line = 1; m.cnt = 0; end
            if (m.in_line && d) begin
                de = 1; sol = (m.cnt == 0); m.pix = p;
                m.x = imin(m.cnt, maxv); m.y = m.row; m.cnt++;
            end
        end
        m.prev_f = f; m.prev_l = le;
        m.pass = {18'd0, m.trunc, eof, sof, eol, sol, de};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.pixel", pix_a, ma.pix);  chk("a.x", x_a, ma.x);  chk("a.y", y_a, ma.y);
        chk("a.col", col_a, ma.col);    chk("a.pass", pass_a, ma.pass);
        chk("b.pixel", pix_b, mb.pix);  chk("b.x", x_b, mb.x);  chk("b.y", y_b, mb.y);
        chk("b.col", col_b, mb.col);    chk("b.pass", pass_b, mb.pass);
    endtask

    task automatic cyc(input bit r, input bit f, input bit l, input bit d, input logic [23:0] p);
        rst = r; in_fval = f; in_lval = l; in_dval = d; in_pixel = p;
        @(posedge clk); #1;
        mstep(ma, r, f, l, d, p, 8191, 640);
        mstep(mb, r, f, l, d, p, 15, 10);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'($urandom), 1'($urandom), 24'($urandom));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 1'($urandom), 24'($urandom));
    endtask

    // dmode 0: dval always 1, pixels base+i; 1: dval from pat (LSB first); 2: random dval/pixels
    task automatic line(input int n, input int dmode, input logic [23:0] base, input logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            case (dmode)
                0:       cyc(0, 1, 1, 1, base + 24'(i));
                1:       cyc(0, 1, 1, pat[i], base + 24'(i));
                default: cyc(0, 1, 1, 1'($urandom), 24'($urandom));
            endcase
        end
    endtask

    initial begin
        // Reset and idle
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst.col", col_a, 640);
        chk("rst.pass", pass_a, 0);
        idle(2);

        // Frame 1: 2 lines of 4 pixels 1..4
        gap(1);
        chk("f1.sof", pass_a, 24'h8);
        line(4, 0, 24'h1, 0);
        gap(1);
        chk("f1.eol", pass_a, 24'h4);
        chk("f1.col", col_a, 4);
        line(4, 0, 24'h1, 0);
        chk("f1.y", y_a, 1);
        chk("f1.x", x_a, 3);
        gap(1);
        cyc(0, 0, 0, 0, 0);
        chk("f1.eof", pass_a, 24'h10);
        idle(2);

        // Frame 2: dval gaps 1,0,1,1,0,1
        gap(1);
        line(6, 1, 24'h10, 32'b101101);
        chk("f2.x", x_a, 3);
        gap(1);
        chk("f2.col", col_a, 4);
        idle(1);

        // Frame 3: fval drops after pixel 2
        gap(1);
        line(5, 0, 24'h20, 0);
        gap(1);
        line(3, 0, 24'h30, 0);
        cyc(0, 0, 1, 0, 0);
        chk("f3.trunc", pass_a, 24'h34);
        chk("f3.col", col_a, 5);
        idle(2);
        chk("f3.sticky", pass_a, 24'h20);

        // Frame 4: trunc clears at sof
        gap(1);
        chk("f4.sof", pass_a, 24'h8);
        line(7, 2, 0, 0);
        gap(2);
        idle(1);

        // Reset released mid-frame with lval active
        cyc(1, 1, 1, 1, 24'h55);
        cyc(1, 1, 1, 1, 24'h56);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 24'h60 + 24'(i));
        chk("mid.pass", pass_a, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        idle(1);
        gap(1);
        chk("mid.sof", pass_a, 24'h8);
        line(3, 0, 24'h70, 0);
        gap(1);
        chk("mid.col", col_a, 3);
        idle(1);

        // 20-pixel line: CW=4 instance saturates
        gap(1);
        line(20, 0, 24'h100, 0);
        chk("sat.x", x_b, 15);
        gap(1);
        chk("sat.col_b", col_b, 15);
        chk("sat.col_a", col_a, 20);
        idle(1);

        // Reset during a line
        gap(1);
        line(3, 0, 24'h200, 0);
        cyc(1, 1, 1, 1, 24'h203);
        chk("rl.col", col_a, 640);
        chk("rl.pass", pass_a, 0);
        chk("rl.pixel", pix_a, 0);
        cyc(0, 1, 1, 1, 24'h204);
        cyc(0, 1, 0, 0, 0);
        idle(2);

        // Random frames
        for (int fr = 0; fr < 40; fr++) begin
            int  nl;
            bit  tr;
            gap($urandom_range(1, 2));
            nl = $urandom_range(0, 4);
            tr = 0;
            for (int j = 0; j < nl; j++) begin
                line($urandom_range(0, 20), 2, 0, 0);
                if (j == nl - 1 && $urandom_range(0, 3) == 0) tr = 1;
                else gap($urandom_range(1, 3));
            end
            if (tr) cyc(0, 0, 1, 1'($urandom), 24'($urandom));
            idle($urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
